// File: rtl/dac_output_pkg.sv
// Shared types and constants for the AD5662-class serial DAC driver.
// The optional pending-frame slot is enabled with DAC_OUTPUT_DOUBLE_BUFFER_EN.
package dac_output_pkg;

  localparam int unsigned FRAME_BITS  = 24;
  localparam int unsigned DATA_BITS   = 16;
  localparam int unsigned PD_BITS     = 2;
  localparam int unsigned PD_BITS_POS = 16;
  localparam int unsigned BIT_CNT_W   = 5;
  localparam int unsigned DIV_W       = 8;

  // Power-down encodings carried in PD[1:0]
  localparam logic [PD_BITS-1:0] PD_NORMAL   = 2'b00;
  localparam logic [PD_BITS-1:0] PD_1K       = 2'b01;
  localparam logic [PD_BITS-1:0] PD_100K     = 2'b10;
  localparam logic [PD_BITS-1:0] PD_TRISTATE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // One frame request as captured from the input ports
  typedef struct packed {
    logic [PD_BITS-1:0]   pd;
    logic [DATA_BITS-1:0] value;
  } frame_req_t;

  // Assemble the on-wire word: leading zeros, PD bits, then the DAC code
  function automatic logic [FRAME_BITS-1:0] build_frame(input frame_req_t req);
    return {{(FRAME_BITS - PD_BITS_POS - PD_BITS){1'b0}}, req.pd, req.value};
  endfunction

endpackage

// File: rtl/dac_sclk_divider.sv
// Half-period tick generator: counts 0..CLK_DIV-1 and ticks on the last count.
module dac_sclk_divider
  import dac_output_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic dataclk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam logic [DIV_W-1:0] LAST_CNT = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count_q;

  assign tick_c = (count_q == LAST_CNT);

  // Free-running divider, restarted whenever the FSM enters a new state
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear || tick_c) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/dac_output.sv
// Serial frame driver for an AD5662-class DAC (SYNC/SCLK/DIN, 24-bit frames).
// Define DAC_OUTPUT_DOUBLE_BUFFER_EN to accept a one-deep pending frame while busy.
module dac_output
  import dac_output_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic                 dataclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] dac_value,
  input  logic [PD_BITS-1:0]   power_down,
  output logic                 busy,
  output logic                 done,
  output logic                 DAC_SYNC,
  output logic                 DAC_SCLK,
  output logic                 DAC_DIN
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]    bit_q, bit_d;
  logic                    low_q, low_d;
  logic                    busy_d, done_d, sync_d, sclk_d, din_d;
  logic                    tick_c;
  logic                    div_clear_c;
  frame_req_t              in_req_c;

`ifdef DAC_OUTPUT_DOUBLE_BUFFER_EN
  frame_req_t              pend_q, pend_d;
  logic                    pend_valid_q, pend_valid_d;
`endif

  assign in_req_c    = '{pd: power_down, value: dac_value};
  assign div_clear_c = (state_d != state_q);

  dac_sclk_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .dataclk (dataclk),
    .reset   (reset),
    .clear   (div_clear_c),
    .tick_c  (tick_c)
  );

  // State, shift data and registered pin values
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bit_q    <= '0;
      low_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      DAC_SYNC <= 1'b1;
      DAC_SCLK <= 1'b1;
      DAC_DIN  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bit_q    <= bit_d;
      low_q    <= low_d;
      busy     <= busy_d;
      done     <= done_d;
      DAC_SYNC <= sync_d;
      DAC_SCLK <= sclk_d;
      DAC_DIN  <= din_d;
    end
  end

`ifdef DAC_OUTPUT_DOUBLE_BUFFER_EN
  // Pending frame slot written by start requests that arrive while busy
  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end
`endif

  // Next-state, frame sequencing and next pin values
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    low_d   = low_q;
    done_d  = 1'b0;

`ifdef DAC_OUTPUT_DOUBLE_BUFFER_EN
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    // Latest request while busy overwrites the slot
    if (start && (state_q != IDLE)) begin
      pend_d       = in_req_c;
      pend_valid_d = 1'b1;
    end
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          shreg_d = build_frame(in_req_c);
          bit_d   = '0;
          low_d   = 1'b0;
        end
      end
      SETUP: begin
        if (tick_c) begin
          state_d = SHIFT;
          bit_d   = '0;
          low_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (tick_c) begin
          if (!low_q) begin
            low_d = 1'b1;
          end else if (bit_q == LAST_BIT) begin
            state_d = HOLD;
            low_d   = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
            low_d   = 1'b0;
            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef DAC_OUTPUT_DOUBLE_BUFFER_EN
          if (pend_valid_d) begin
            state_d      = SETUP;
            shreg_d      = build_frame(pend_d);
            bit_d        = '0;
            low_d        = 1'b0;
            pend_valid_d = 1'b0;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    sync_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    sclk_d = !((state_d == SHIFT) && low_d);
    din_d  = ((state_d == SETUP) || (state_d == SHIFT)) ? shreg_d[FRAME_BITS-1] : 1'b0;
  end

endmodule

// File: doc/dac_output.md
DAC_OUTPUT -- requirements
Module: dac_output

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning SCLK half-period in dataclk cycles (legal range 1..255).
REQ-002 SHALL have port dataclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one frame; sampled every cycle.
REQ-005 SHALL have port dac_value  input  16  DAC code, MSB first on the wire.
REQ-006 SHALL have port power_down  input  2  power-down bits PD[1:0] for the frame.
REQ-007 SHALL have port busy  output  1  high while a frame is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port DAC_SYNC  output  1  active-low frame select to the AD5662-class DAC.
REQ-010 SHALL have port DAC_SCLK  output  1  serial clock; idles high.
REQ-011 SHALL have port DAC_DIN  output  1  serial data; changes only on DAC_SCLK rising edges.

Function
REQ-012 SHALL send 24-bit frames: 6 zeros, PD[1:0], dac_value[15:0], in that order, MSB first.
REQ-013 SHALL latch dac_value and power_down in the cycle start is accepted; later input changes SHALL NOT affect that frame.
REQ-014 SHALL accept start only in IDLE; busy SHALL rise the cycle after acceptance.
REQ-015 SHALL use states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-016 SETUP: DAC_SYNC low, DAC_SCLK high, DAC_DIN = frame bit 23; lasts CLK_DIV cycles.
REQ-017 SHIFT: per bit, DAC_SCLK high for CLK_DIV cycles, then low for CLK_DIV cycles; DIN updates to the next bit as SCLK rises; 24 bits.
REQ-018 HOLD: DAC_SYNC low, DAC_SCLK high, CLK_DIV cycles. GAP: DAC_SYNC high, CLK_DIV cycles.
REQ-019 Busy SHALL last exactly 51*CLK_DIV cycles; done SHALL pulse in the first IDLE cycle after GAP, with busy low in that cycle.
REQ-020 SHALL keep DAC_DIN at 0 outside SETUP/SHIFT.
REQ-021 start held high continuously SHALL produce back-to-back frames, each separated by the GAP state plus one IDLE cycle.

Reset
REQ-022 On reset, outputs SHALL be immediately DAC_SYNC=1, DAC_SCLK=1, DAC_DIN=0, busy=0, done=0; state = IDLE; latches cleared to 0.
REQ-023 Reset mid-frame SHALL abort the frame with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-024 With DAC_OUTPUT_DOUBLE_BUFFER_EN defined, a start while busy SHALL latch value/PD into a one-deep pending slot (latest write wins), and that frame SHALL begin directly from GAP without an IDLE cycle; done SHALL still pulse once per frame.
REQ-025 Without DAC_OUTPUT_DOUBLE_BUFFER_EN, start while busy SHALL be ignored and no pending slot SHALL exist.

Structure
REQ-026 Package dac_output_pkg SHALL hold the state enum, FRAME_BITS=24, PD_BITS_POS, and PD encodings (NORMAL=2'b00, 1K=2'b01, 100K=2'b10, TRISTATE=2'b11).
REQ-027 The half-period tick generator SHALL be a sub-module dac_sclk_divider (count 0..CLK_DIV-1, tick on wrap, cleared on state entry).

Verification
REQ-028 CLK_DIV=2, start pulse with dac_value=16'hA5C3, PD=00 -> 24 captured bits on SCLK falling edges = 24'h00A5C3; busy high 102 cycles; one done pulse.
REQ-029 PD=2'b11, dac_value=16'h0000 -> captured frame 24'h030000.
REQ-030 dac_value changed to 16'hFFFF two cycles after accepting 16'h1234 -> frame carries 16'h1234.
REQ-031 Reset asserted 40 cycles into a frame -> SYNC/SCLK high, DIN 0 with no clock edge; no done; next start produces a complete correct frame.
REQ-032 Without macro, second start 10 cycles after the first -> exactly one frame and one done. With macro, starts of 16'h1111 then 16'h2222 and 16'h3333 while busy -> frames 1111 then 3333, two done pulses, 204 busy cycles contiguous.
REQ-033 CLK_DIV=1, start held high for 200 cycles -> frames separated by 1 GAP + 1 IDLE cycle; SCLK period 2 cycles.
